// File: rtl/regfile_alu.sv
// regfile_alu: 8 x N register file feeding a two-stage fetch / execute-writeback ALU.
// Define REGFILE_ALU_FWD_EN to bypass the execute result instead of stalling on hazards.
module regfile_alu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   operacion,
    input  logic [2:0]   a0,
    input  logic [2:0]   a1,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         we,
    output logic         stall,
    output logic [N-1:0] result,
    output logic         result_valid,
    output logic         zero,
    output logic         carry,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_ADDI = 3'b111
    } op_e;

    logic [N-1:0] rf_q [8];

    logic         v1_q;
    op_e          op1_q;
    logic [2:0]   dst1_q;
    logic [N-1:0] srcA1_q;
    logic [N-1:0] srcB1_q;
    logic [N-1:0] imm1_q;

    logic [N-1:0] result_q;
    logic         result_valid_q;
    logic         zero_q;
    logic         carry_q;

    op_e          op_in;
    logic         issue;
    logic         v1_d;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic [N-1:0] imm_d;

    logic [N:0]   sum;
    logic [N-1:0] alu_res;
    logic         alu_c;

    assign op_in = op_e'(operacion);
    assign issue = we && (op_in != OP_NOP);

`ifdef REGFILE_ALU_FWD_EN
    assign stall = 1'b0;
    assign opa   = (v1_q && dst1_q == a0) ? alu_res : rf_q[a0];
    assign opb   = (v1_q && dst1_q == a1) ? alu_res : rf_q[a1];
`else
    logic rd_a;
    logic rd_b;
    // a0 is a source for ADD..XOR, a1 for everything from ADD up
    assign rd_a  = (operacion >= 3'd2) && (operacion <= 3'd6);
    assign rd_b  = (operacion >= 3'd2);
    assign stall = v1_q && issue
                   && ((rd_a && a0 == dst1_q) || (rd_b && a1 == dst1_q));
    assign opa   = rf_q[a0];
    assign opb   = rf_q[a1];
`endif

    assign v1_d  = issue && !stall;
    assign imm_d = (op_in == OP_LDI) ? d0 : d1;

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (op1_q)
            OP_LDI: alu_res = imm1_q;
            OP_ADD: begin
                sum     = {1'b0, srcA1_q} + {1'b0, srcB1_q};
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
            end
            OP_SUB: begin
                alu_res = srcA1_q - srcB1_q;
                alu_c   = srcA1_q < srcB1_q;
            end
            OP_AND: alu_res = srcA1_q & srcB1_q;
            OP_OR:  alu_res = srcA1_q | srcB1_q;
            OP_XOR: alu_res = srcA1_q ^ srcB1_q;
            OP_ADDI: begin
                sum     = {1'b0, srcB1_q} + {1'b0, imm1_q};
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
            v1_q           <= 1'b0;
            op1_q          <= OP_NOP;
            dst1_q         <= '0;
            srcA1_q        <= '0;
            srcB1_q        <= '0;
            imm1_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            zero_q         <= 1'b0;
            carry_q        <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (v1_d) begin
                op1_q   <= op_in;
                dst1_q  <= a0;
                srcA1_q <= opa;
                srcB1_q <= opb;
                imm1_q  <= imm_d;
            end
            result_valid_q <= v1_q;
            if (v1_q) begin
                rf_q[dst1_q] <= alu_res;
                result_q     <= alu_res;
                zero_q       <= (alu_res == '0);
                carry_q      <= alu_c;
            end
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign zero         = zero_q;
    assign carry        = carry_q;
    assign dbg_data     = rf_q[dbg_addr];

endmodule
